// File: rtl/tight_acc_mem_rob.sv
// rtl/tight_acc_mem_rob.sv - in-order L2 transaction ID allocator and response reorder buffer
module tight_acc_mem_rob #(
  parameter int DEPTH = 16,
  parameter int DW    = 64,
  parameter int PADDR = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc_req_val,
  output logic             acc_req_rdy,
  input  logic [PADDR-1:0] acc_req_addr,
  output logic             mem_req_val,
  input  logic             mem_req_rdy,
  output logic [5:0]       mem_req_transid,
  output logic [PADDR-1:0] mem_req_addr,
  input  logic             mem_resp_val,
  input  logic [5:0]       mem_resp_transid,
  input  logic [DW-1:0]    mem_resp_data,
  output logic             acc_resp_val,
  input  logic             acc_resp_rdy,
  output logic [DW-1:0]    acc_resp_data,
  output logic [6:0]       outstanding,
  output logic             err_unexp_resp
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW-1:0]    count;
  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] filled;
  logic [DEPTH-1:0] pending_nxt;
  logic [DEPTH-1:0] filled_nxt;
  logic [DW-1:0]    data_mem [DEPTH];
  logic [IW-1:0]    head_idx;
  logic [IW-1:0]    tail_idx;
  logic [IW-1:0]    resp_idx;
  logic             full;
  logic             alloc;
  logic             pop;
  logic             resp_in_range;
  logic             resp_ok;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  assign count    = tail - head;
  assign full     = (count == PW'(DEPTH));
  assign head_idx = head[IW-1:0];
  assign tail_idx = tail[IW-1:0];
  assign resp_idx = mem_resp_transid[IW-1:0];

  assign mem_req_val     = acc_req_val & ~full;
  assign acc_req_rdy     = mem_req_rdy & ~full;
  assign mem_req_transid = 6'(tail_idx);
  assign mem_req_addr    = acc_req_addr;

  assign alloc = mem_req_val & mem_req_rdy;
  assign pop   = acc_resp_val & acc_resp_rdy;

  assign resp_in_range = ({1'b0, mem_resp_transid} < 7'(DEPTH));
  assign resp_ok       = mem_resp_val & resp_in_range & pending[resp_idx] & ~filled[resp_idx];

  assign acc_resp_val  = filled[head_idx];
  assign acc_resp_data = data_mem[head_idx];
  assign outstanding   = 7'(count);

  // Pop, allocate and response never target the same slot in one cycle.
  always_comb begin
    pending_nxt = pending;
    filled_nxt  = filled;
    if (pop) begin
      pending_nxt[head_idx] = 1'b0;
      filled_nxt[head_idx]  = 1'b0;
    end
    if (alloc) begin
      pending_nxt[tail_idx] = 1'b1;
      filled_nxt[tail_idx]  = 1'b0;
    end
    if (resp_ok) begin
      filled_nxt[resp_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head           <= '0;
      tail           <= '0;
      pending        <= '0;
      filled         <= '0;
      err_unexp_resp <= 1'b0;
    end else begin
      if (alloc) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      if (mem_resp_val && !resp_ok) begin
        err_unexp_resp <= 1'b1;
      end
      pending <= pending_nxt;
      filled  <= filled_nxt;
    end
  end

  // Payload storage needs no reset: a slot is only read once its filled bit is set.
  always_ff @(posedge clk) begin
    if (resp_ok) begin
      data_mem[resp_idx] <= mem_resp_data;
    end
  end

endmodule

// File: tb/tb_tight_acc_mem_rob.sv
// tb/tb_tight_acc_mem_rob.sv - directed and random checks of tight_acc_mem_rob against an in-order queue model
module tb_tight_acc_mem_rob;

  localparam int DEPTH = 16;
  localparam int DW    = 64;
  localparam int PADDR = 40;

  logic             clk;
  logic             rst_n;
  logic             acc_req_val;
  logic             acc_req_rdy;
  logic [PADDR-1:0] acc_req_addr;
  logic             mem_req_val;
  logic             mem_req_rdy;
  logic [5:0]       mem_req_transid;
  logic [PADDR-1:0] mem_req_addr;
  logic             mem_resp_val;
  logic [5:0]       mem_resp_transid;
  logic [DW-1:0]    mem_resp_data;
  logic             acc_resp_val;
  logic             acc_resp_rdy;
  logic [DW-1:0]    acc_resp_data;
  logic [6:0]       outstanding;
  logic             err_unexp_resp;

  tight_acc_mem_rob #(.DEPTH(DEPTH), .DW(DW), .PADDR(PADDR)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .acc_req_val      (acc_req_val),
    .acc_req_rdy      (acc_req_rdy),
    .acc_req_addr     (acc_req_addr),
    .mem_req_val      (mem_req_val),
    .mem_req_rdy      (mem_req_rdy),
    .mem_req_transid  (mem_req_transid),
    .mem_req_addr     (mem_req_addr),
    .mem_resp_val     (mem_resp_val),
    .mem_resp_transid (mem_resp_transid),
    .mem_resp_data    (mem_resp_data),
    .acc_resp_val     (acc_resp_val),
    .acc_resp_rdy     (acc_resp_rdy),
    .acc_resp_data    (acc_resp_data),
    .outstanding      (outstanding),
    .err_unexp_resp   (err_unexp_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference: outstanding requests in issue order, each with its ID and fill state.
  int            q_id[$];
  bit            q_filled[$];
  logic [DW-1:0] q_data[$];
  int            alloc_count;
  bit            err_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_id.delete();
    q_filled.delete();
    q_data.delete();
    alloc_count = 0;
    err_m = 1'b0;
  endtask

  task automatic check_model();
    int n;
    n = q_id.size();
    chk("acc_req_rdy", 64'(acc_req_rdy), 64'(mem_req_rdy && n < DEPTH));
    chk("mem_req_val", 64'(mem_req_val), 64'(acc_req_val && n < DEPTH));
    chk("mem_req_transid", 64'(mem_req_transid), 64'(alloc_count % DEPTH));
    chk("mem_req_addr", 64'(mem_req_addr), 64'(acc_req_addr));
    chk("outstanding", 64'(outstanding), 64'(n));
    chk("acc_resp_val", 64'(acc_resp_val), 64'(n > 0 && q_filled[0]));
    if (n > 0 && q_filled[0]) chk("acc_resp_data", acc_resp_data, q_data[0]);
    chk("err_unexp_resp", 64'(err_unexp_resp), 64'(err_m));
  endtask

  // Applies the sampled inputs to the reference using the pre-edge contents.
  task automatic model_update();
    int  n;
    bit  found;
    bit  do_pop;
    bit  do_alloc;
    n = q_id.size();
    do_pop   = (n > 0) && q_filled[0] && acc_resp_rdy;
    do_alloc = acc_req_val && mem_req_rdy && (n < DEPTH);
    if (mem_resp_val) begin
      found = 1'b0;
      for (int k = 0; k < n; k++) begin
        if (q_id[k] == int'(mem_resp_transid) && !q_filled[k]) begin
          q_filled[k] = 1'b1;
          q_data[k]   = mem_resp_data;
          found       = 1'b1;
        end
      end
      if (!found) err_m = 1'b1;
    end
    if (do_pop) begin
      void'(q_id.pop_front());
      void'(q_filled.pop_front());
      void'(q_data.pop_front());
    end
    if (do_alloc) begin
      q_id.push_back(alloc_count % DEPTH);
      q_filled.push_back(1'b0);
      q_data.push_back('0);
      alloc_count++;
    end
  endtask

  task automatic drive(input bit rqv, input bit mrdy, input logic [PADDR-1:0] addr,
                       input bit rsv, input logic [5:0] rsid, input logic [DW-1:0] rsd,
                       input bit rprdy);
    acc_req_val      = rqv;
    mem_req_rdy      = mrdy;
    acc_req_addr     = addr;
    mem_resp_val     = rsv;
    mem_resp_transid = rsid;
    mem_resp_data    = rsd;
    acc_resp_rdy     = rprdy;
    #1;
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(0, 0, '0, 0, '0, '0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int o;
    int cand[$];
    rst_n = 1'b0;
    acc_req_val = 0; mem_req_rdy = 0; acc_req_addr = '0; mem_resp_val = 0;
    mem_resp_transid = '0; mem_resp_data = '0; acc_resp_rdy = 0;
    model_reset();
    #2;
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_acc_resp_val", 64'(acc_resp_val), 64'd0);
    chk("rst_err", 64'(err_unexp_resp), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single load round trip
    drive(1, 1, 40'h1000, 0, 0, 0, 1);
    chk("t1_transid", 64'(mem_req_transid), 64'd0);
    tick();
    drive(0, 1, '0, 1, 6'd0, 64'hAB, 1);
    chk("t1_out1", 64'(outstanding), 64'd1);
    chk("t1_no_val_yet", 64'(acc_resp_val), 64'd0);
    tick();
    drive(0, 1, '0, 0, 0, 0, 1);
    chk("t1_val", 64'(acc_resp_val), 64'd1);
    chk("t1_data", acc_resp_data, 64'hAB);
    tick();
    drive(0, 1, '0, 0, 0, 0, 1);
    chk("t1_out0", 64'(outstanding), 64'd0);
    tick();

    // Out-of-order responses return in issue order
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 40'(32'h100 * i), 0, 0, 0, 1);
      chk("t2_transid", 64'(mem_req_transid), 64'(i));
      tick();
    end
    drive(0, 1, '0, 1, 6'd2, 64'h22, 1);
    tick();
    drive(0, 1, '0, 1, 6'd0, 64'h10, 1);
    chk("t2_no_early", 64'(acc_resp_val), 64'd0);
    tick();
    drive(0, 1, '0, 1, 6'd1, 64'h11, 1);
    chk("t2_first", acc_resp_data, 64'h10);
    tick();
    drive(0, 1, '0, 0, 0, 0, 1);
    chk("t2_second", acc_resp_data, 64'h11);
    tick();
    drive(0, 1, '0, 0, 0, 0, 1);
    chk("t2_third", acc_resp_data, 64'h22);
    tick();
    drive(0, 1, '0, 0, 0, 0, 1);
    chk("t2_empty", 64'(outstanding), 64'd0);
    tick();

    // Fill to DEPTH, then pop one and observe the wrap
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 1, 40'h2000 + 40'(i), 0, 0, 0, 0);
      tick();
    end
    drive(1, 1, 40'h2000, 1, 6'd0, 64'hA0, 0);
    chk("t3_full_rdy", 64'(acc_req_rdy), 64'd0);
    chk("t3_full_out", 64'(outstanding), 64'd16);
    tick();
    drive(1, 1, 40'h2000, 0, 0, 0, 1);
    chk("t3_pop_rdy", 64'(acc_req_rdy), 64'd0);
    tick();
    drive(1, 1, 40'h2000, 0, 0, 0, 0);
    chk("t3_resume_rdy", 64'(acc_req_rdy), 64'd1);
    chk("t3_wrap_id", 64'(mem_req_transid), 64'd0);
    tick();

    // Backpressure holds data; allocate and pop together
    drive(0, 1, '0, 1, 6'd1, 64'h5A5A, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, '0, 0, 0, 0, 0);
      chk("t4_hold", acc_resp_data, 64'h5A5A);
      tick();
    end
    drive(0, 1, '0, 1, 6'd2, 64'h77, 1);
    tick();
    o = q_id.size();
    drive(1, 1, 40'h3000, 0, 0, 0, 1);
    chk("t4_both_val", 64'(acc_resp_val & mem_req_val), 64'd1);
    tick();
    drive(0, 1, '0, 0, 0, 0, 0);
    chk("t4_out_same", 64'(outstanding), 64'(o));
    tick();

    // Randomized traffic, valid responses only
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      bit rsv;
      int pick;
      cand.delete();
      for (int k = 0; k < q_id.size(); k++) if (!q_filled[k]) cand.push_back(q_id[k]);
      rsv  = (cand.size() > 0) && ($urandom_range(0, 1) == 1);
      pick = (cand.size() > 0) ? cand[$urandom_range(0, cand.size() - 1)] : 0;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 40'({$urandom, $urandom}),
            rsv, 6'(pick), {$urandom, $urandom}, $urandom_range(0, 2) != 0);
      tick();
    end

    // Unexpected responses are dropped and latch the error
    do_reset();
    drive(0, 1, '0, 1, 6'd5, 64'h55, 0);
    tick();
    drive(0, 1, '0, 1, 6'd20, 64'h66, 0);
    chk("t5_err_after5", 64'(err_unexp_resp), 64'd1);
    tick();
    drive(0, 1, '0, 0, 0, 0, 0);
    chk("t5_err_sticky", 64'(err_unexp_resp), 64'd1);
    chk("t5_out", 64'(outstanding), 64'd0);
    chk("t5_val", 64'(acc_resp_val), 64'd0);
    tick();
    drive(1, 1, 40'h4000, 0, 0, 0, 0);
    tick();
    drive(0, 1, '0, 1, 6'd0, 64'h33, 0);
    tick();
    drive(0, 1, '0, 1, 6'd0, 64'h44, 0);
    tick();
    drive(0, 1, '0, 0, 0, 0, 1);
    chk("t5_dup_dropped", acc_resp_data, 64'h33);
    tick();

    // Asynchronous reset mid-operation, then a stale response
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 40'h5000 + 40'(i), 0, 0, 0, 0);
      tick();
    end
    drive(0, 1, '0, 1, 6'd0, 64'h99, 0);
    tick();
    drive(0, 1, '0, 0, 0, 0, 0);
    chk("t6_pre_out", 64'(outstanding), 64'd4);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_out", 64'(outstanding), 64'd0);
    chk("t6_rst_val", 64'(acc_resp_val), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(0, 1, '0, 1, 6'd1, 64'hBB, 0);
    tick();
    drive(0, 1, '0, 0, 0, 0, 0);
    chk("t6_stale_err", 64'(err_unexp_resp), 64'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
